seg_execute_alu_ctl_stage: RTL and testbench

//  ID/EX boundary stage that encodes ALU control and feeds the execute ALU.
//  - Encodes decoder-side ALUOp/funct/opcode into the 4-bit ALU control code and registers it.
//  - Registers the operand pair alongside it, so the ALU sees code and operands in the same cycle.
//  - Provides valid/stall/flush pipeline control, an illegal-op flag and an issue counter.

---
 rtl/seg_execute_alu_ctl_stage.sv | 139 +++++++++++++
 tb/tb_seg_execute_alu_ctl_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_execute_alu_ctl_stage.sv
// ID/EX boundary register: encodes ALUOp/funct/opcode into the ALU control code and
// registers it with the operand pair, plus valid/stall/flush control and an issue counter.
module seg_execute_alu_ctl_stage #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALUCTL = 4,
  parameter int NB_CNT    = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [1:0]           i_ALUOp,
  input  logic [5:0]           i_funct,
  input  logic [5:0]           i_opcode,
  input  logic [NB_DATA-1:0]   i_data_a,
  input  logic [NB_DATA-1:0]   i_data_b,
  output logic [NB_ALUCTL-1:0] o_ALUctl,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic                 o_valid,
  output logic                 o_illegal,
  output logic [NB_CNT-1:0]    o_issue_count
);

  localparam logic [NB_ALUCTL-1:0] CTL_AND = NB_ALUCTL'(4'b0000);
  localparam logic [NB_ALUCTL-1:0] CTL_OR  = NB_ALUCTL'(4'b0001);
  localparam logic [NB_ALUCTL-1:0] CTL_ADD = NB_ALUCTL'(4'b0010);
  localparam logic [NB_ALUCTL-1:0] CTL_SUB = NB_ALUCTL'(4'b0110);
  localparam logic [NB_ALUCTL-1:0] CTL_SLT = NB_ALUCTL'(4'b0111);
  localparam logic [NB_ALUCTL-1:0] CTL_NOR = NB_ALUCTL'(4'b1100);
  localparam logic [NB_ALUCTL-1:0] CTL_XOR = NB_ALUCTL'(4'b1101);
  localparam logic [NB_ALUCTL-1:0] CTL_NOP = NB_ALUCTL'(4'b1111);

  // Returns {illegal, code}; unencodable funct/opcode yields NOP with illegal set.
  function automatic logic [NB_ALUCTL:0] encode_ctl(input logic [1:0] aluop,
                                                   input logic [5:0] funct,
                                                   input logic [5:0] opcode);
    logic [NB_ALUCTL-1:0] code;
    logic                 ill;
    code = CTL_NOP;
    ill  = 1'b0;
    case (aluop)
      2'b00: code = CTL_ADD;
      2'b01: code = CTL_SUB;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: code = CTL_ADD;
          6'b100010, 6'b100011: code = CTL_SUB;
          6'b100100:            code = CTL_AND;
          6'b100101:            code = CTL_OR;
          6'b100110:            code = CTL_XOR;
          6'b100111:            code = CTL_NOR;
          6'b101010:            code = CTL_SLT;
          default:              ill  = 1'b1;
        endcase
      end
      default: begin
        case (opcode)
          6'b001000, 6'b001001: code = CTL_ADD;
          6'b001100:            code = CTL_AND;
          6'b001101:            code = CTL_OR;
          6'b001110:            code = CTL_XOR;
          6'b001010:            code = CTL_SLT;
          default:              ill  = 1'b1;
        endcase
      end
    endcase
    return {ill, code};
  endfunction

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + NB_CNT'(1);
  endfunction

  logic [NB_ALUCTL-1:0] ctl_q, ctl_d;
  logic [NB_DATA-1:0]   a_q, a_d, b_q, b_d;
  logic                 vld_q, vld_d;
  logic                 ill_q, ill_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  logic [NB_ALUCTL:0]   enc;

  assign enc = encode_ctl(i_ALUOp, i_funct, i_opcode);

  // Next-state: flush beats stall beats load.
  always_comb begin
    ctl_d = ctl_q;
    a_d   = a_q;
    b_d   = b_q;
    vld_d = vld_q;
    ill_d = ill_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      ctl_d = CTL_NOP;
      a_d   = '0;
      b_d   = '0;
      vld_d = 1'b0;
      ill_d = 1'b0;
    end else if (!i_stall) begin
      vld_d = i_valid;
      a_d   = i_data_a;
      b_d   = i_data_b;
      if (i_valid) begin
        ctl_d = enc[NB_ALUCTL-1:0];
        ill_d = enc[NB_ALUCTL];
        cnt_d = sat_inc(cnt_q);
      end else begin
        ctl_d = CTL_NOP;
        ill_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ctl_q <= CTL_NOP;
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_ALUctl      = ctl_q;
  assign o_data_a      = a_q;
  assign o_data_b      = b_q;
  assign o_valid       = vld_q;
  assign o_illegal     = ill_q;
  assign o_issue_count = cnt_q;

endmodule

// File: tb/tb_seg_execute_alu_ctl_stage.sv
// Bench for seg_execute_alu_ctl_stage: vector table, directed corner sequences and
// randomized traffic against a table-lookup reference model.
module tb_seg_execute_alu_ctl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, stall, flush;
  logic [1:0]  aluop;
  logic [5:0]  funct, opcode;
  logic [31:0] da, db;

  logic [3:0]  ctl_o, ctl2_o;
  logic [31:0] a_o, b_o, a2_o, b2_o;
  logic        vld_o, ill_o, vld2_o, ill2_o;
  logic [15:0] cnt_o;
  logic [1:0]  cnt2_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg_execute_alu_ctl_stage dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_ALUOp(aluop), .i_funct(funct), .i_opcode(opcode), .i_data_a(da), .i_data_b(db),
    .o_ALUctl(ctl_o), .o_data_a(a_o), .o_data_b(b_o), .o_valid(vld_o),
    .o_illegal(ill_o), .o_issue_count(cnt_o)
  );

  seg_execute_alu_ctl_stage #(.NB_CNT(2)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_ALUOp(aluop), .i_funct(funct), .i_opcode(opcode), .i_data_a(da), .i_data_b(db),
    .o_ALUctl(ctl2_o), .o_data_a(a2_o), .o_data_b(b2_o), .o_valid(vld2_o),
    .o_illegal(ill2_o), .o_issue_count(cnt2_o)
  );

  // Reference lookup tables: legal funct/opcode values and their control codes.
  int rfun[9]  = '{32, 33, 34, 35, 36, 37, 38, 39, 42};
  int rcode[9] = '{ 2,  2,  6,  6,  0,  1, 13, 12,  7};
  int ifun[6]  = '{ 8,  9, 12, 13, 14, 10};
  int icode[6] = '{ 2,  2,  0,  1, 13,  7};

  // Expected state of the stage
  int          m_ctl, m_valid, m_ill, m_cnt, m_cnt2;
  logic [31:0] m_a, m_b;

  function automatic void ref_encode(input int op, input int fn, input int opc,
                                     output int code, output int ill);
    code = 15;
    ill  = 1;
    if (op == 0) begin code = 2; ill = 0; end
    else if (op == 1) begin code = 6; ill = 0; end
    else if (op == 2) begin
      for (int i = 0; i < 9; i++) if (rfun[i] == fn) begin code = rcode[i]; ill = 0; end
    end else begin
      for (int i = 0; i < 6; i++) if (ifun[i] == opc) begin code = icode[i]; ill = 0; end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ctl"},   64'(ctl_o),  64'(m_ctl));
    check({tag, ".a"},     64'(a_o),    64'(m_a));
    check({tag, ".b"},     64'(b_o),    64'(m_b));
    check({tag, ".valid"}, 64'(vld_o),  64'(m_valid));
    check({tag, ".ill"},   64'(ill_o),  64'(m_ill));
    check({tag, ".cnt"},   64'(cnt_o),  64'(m_cnt));
    check({tag, ".cnt2"},  64'(cnt2_o), 64'(m_cnt2));
  endtask

  task automatic model_reset();
    m_ctl = 15; m_a = 0; m_b = 0; m_valid = 0; m_ill = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_edge();
    int code, ill;
    if (flush) begin
      m_valid = 0; m_ctl = 15; m_a = 0; m_b = 0; m_ill = 0;
    end else if (!stall) begin
      m_valid = int'(valid);
      m_a = da;
      m_b = db;
      if (valid) begin
        ref_encode(int'(aluop), int'(funct), int'(opcode), code, ill);
        m_ctl = code;
        m_ill = ill;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end else begin
        m_ctl = 15;
        m_ill = 0;
      end
    end
  endtask

  task automatic set_in(input logic v, input logic s, input logic f, input logic [1:0] op,
                        input logic [5:0] fn, input logic [5:0] opc,
                        input logic [31:0] a, input logic [31:0] b);
    valid = v; stall = s; flush = f; aluop = op; funct = fn; opcode = opc; da = a; db = b;
  endtask

  // One clock: inputs already applied, update model at the edge, sample 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse between edges, with stall high to show it is ignored.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    stall = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic        ill;
  } vec_t;

  vec_t vecs[16];
  int   cnt_before;

  initial begin
    vecs[0]  = '{2'b00, 6'h3F, 6'h3F, 32'h1,        32'h2,        4'b0010, 1'b0};
    vecs[1]  = '{2'b01, 6'h00, 6'h00, 32'h3,        32'h4,        4'b0110, 1'b0};
    vecs[2]  = '{2'b10, 6'b100000, 6'h0, 32'hA,     32'hB,        4'b0010, 1'b0};
    vecs[3]  = '{2'b10, 6'b100011, 6'h0, 32'hFFFF_FFFF, 32'h0,    4'b0110, 1'b0};
    vecs[4]  = '{2'b10, 6'b100100, 6'h0, 32'h1234,  32'h5678,     4'b0000, 1'b0};
    vecs[5]  = '{2'b10, 6'b100101, 6'h0, 32'h8000_0000, 32'h1,    4'b0001, 1'b0};
    vecs[6]  = '{2'b10, 6'b100110, 6'h0, 32'h55,    32'hAA,       4'b1101, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 6'h0, 32'h0F,    32'hF0,       4'b1100, 1'b0};
    vecs[8]  = '{2'b10, 6'b101011, 6'h0, 32'h7,     32'h8,        4'b1111, 1'b1};
    vecs[9]  = '{2'b11, 6'h0, 6'b001001, 32'h9,     32'hA,        4'b0010, 1'b0};
    vecs[10] = '{2'b11, 6'h0, 6'b001100, 32'hB,     32'hC,        4'b0000, 1'b0};
    vecs[11] = '{2'b11, 6'h0, 6'b001101, 32'hD,     32'hE,        4'b0001, 1'b0};
    vecs[12] = '{2'b11, 6'h0, 6'b001010, 32'hF,     32'h10,       4'b0111, 1'b0};
    vecs[13] = '{2'b11, 6'h0, 6'b001011, 32'h11,    32'h12,       4'b1111, 1'b1};
    vecs[14] = '{2'b11, 6'b100000, 6'b000000, 32'h13, 32'h14,     4'b1111, 1'b1};
    vecs[15] = '{2'b10, 6'b000000, 6'b001000, 32'h15, 32'h16,     4'b1111, 1'b1};

    rst = 1'b1;
    set_in(0, 0, 0, 2'b00, 6'h0, 6'h0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // R-type SLT
    set_in(1, 0, 0, 2'b10, 6'b101010, 6'h0, 32'd5, 32'd9);
    step();
    check("slt.ctl", 64'(ctl_o), 64'h7);
    check("slt.a", 64'(a_o), 64'd5);
    check("slt.b", 64'(b_o), 64'd9);
    check("slt.valid", 64'(vld_o), 64'd1);
    check("slt.cnt", 64'(cnt_o), 64'd1);

    // Immediate XORI then unencodable opcode
    set_in(1, 0, 0, 2'b11, 6'h0, 6'b001110, 32'd1, 32'd2);
    step();
    check("xori.ctl", 64'(ctl_o), 64'hD);
    check("xori.ill", 64'(ill_o), 64'd0);
    set_in(1, 0, 0, 2'b11, 6'h0, 6'b000011, 32'd3, 32'd4);
    step();
    check("illop.ctl", 64'(ctl_o), 64'hF);
    check("illop.ill", 64'(ill_o), 64'd1);
    check("illop.cnt", 64'(cnt_o), 64'd3);
    check_all("illop");

    // Bubble: valid low clears illegal and forces NOP, counter holds
    set_in(0, 0, 0, 2'b10, 6'b100000, 6'h0, 32'hDEAD, 32'hBEEF);
    step();
    check_all("bubble");
    check("bubble.cnt", 64'(cnt_o), 64'd3);

    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 0, vecs[i].op, vecs[i].fn, vecs[i].opc, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d.ctl", i), 64'(ctl_o), 64'(vecs[i].ctl));
      check($sformatf("vec%0d.ill", i), 64'(ill_o), 64'(vecs[i].ill));
      check($sformatf("vec%0d.a", i), 64'(a_o), 64'(vecs[i].a));
      check_all($sformatf("vec%0d", i));
    end

    // Stall: load ADD then freeze for three cycles under changing inputs
    set_in(1, 0, 0, 2'b00, 6'h0, 6'h0, 32'd7, 32'd8);
    step();
    cnt_before = int'(cnt_o);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 2'(i + 1), 6'($urandom), 6'($urandom), $urandom, $urandom);
      step();
      check("stall.ctl", 64'(ctl_o), 64'h2);
      check("stall.a", 64'(a_o), 64'd7);
      check("stall.b", 64'(b_o), 64'd8);
      check("stall.valid", 64'(vld_o), 64'd1);
      check("stall.cnt", 64'(cnt_o), 64'(cnt_before));
    end

    // Flush with stall and a valid input
    set_in(1, 1, 1, 2'b10, 6'b100000, 6'h0, 32'd11, 32'd12);
    step();
    check("flush.valid", 64'(vld_o), 64'd0);
    check("flush.ctl", 64'(ctl_o), 64'hF);
    check("flush.a", 64'(a_o), 64'd0);
    check("flush.b", 64'(b_o), 64'd0);
    check("flush.cnt", 64'(cnt_o), 64'(cnt_before));
    check_all("flush");

    // Mid-stall asynchronous reset
    set_in(1, 0, 0, 2'b01, 6'h0, 6'h0, 32'd21, 32'd22);
    step();
    reset_pulse("rst_mid");

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 2'b00, 6'h0, 6'h0, 32'(i), 32'(i));
      step();
      check($sformatf("sat%0d.cnt2", i), 64'(cnt2_o), 64'((i < 3) ? i + 1 : 3));
    end
    check_all("sat");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] fn, opc;
      fn  = ($urandom_range(0, 1) == 0) ? 6'(rfun[$urandom_range(0, 8)]) : 6'($urandom);
      opc = ($urandom_range(0, 1) == 0) ? 6'(ifun[$urandom_range(0, 5)]) : 6'($urandom);
      set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 9) == 0), 2'($urandom), fn, opc, $urandom, $urandom);
      step();
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
